// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, multicycle states,
// datapath mux encodings and the multicycle control word.
package mips_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    localparam logic [OP_W-1:0] R_FORMAT = 6'd0;
    localparam logic [OP_W-1:0] LW       = 6'd35;
    localparam logic [OP_W-1:0] SW       = 6'd43;
    localparam logic [OP_W-1:0] BEQ      = 6'd4;
    localparam logic [OP_W-1:0] J        = 6'd2;
    localparam logic [OP_W-1:0] ADDI     = 6'd8;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_SH2  = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore control-word decode for the multicycle controller; only the
// FETCH and MEMWR handshake terms look at mem_ready.
module mc_output_decode
    import mips_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               mem_ready,
    output ctrl_t              ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: ctrl.alu_src_b = SRCB_SH2;
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            RWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/single_cycle_control.sv
// Single-cycle MIPS main control, sharing opcode and ALUOp
// encodings with the multicycle controller.
module single_cycle_control
    import mips_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic            RegDst,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic            Jump,
    output logic [1:0]      ALUOp
);

    always_comb begin
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        ALUOp    = ALU_ADD;
        case (op)
            R_FORMAT: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                ALUOp    = ALU_FUNCT;
            end
            LW: begin
                ALUSrc   = 1'b1;
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                MemRead  = 1'b1;
            end
            SW: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            BEQ: begin
                Branch = 1'b1;
                ALUOp  = ALU_SUB;
            end
            J:    Jump = 1'b1;
            ADDI: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: state register, next-state
// logic and reset gating around the control-word decoder.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               op_bad;
    ctrl_t              ctrl;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        op_bad  = 1'b0;
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    LW, SW:   state_d = MEMADR;
                    R_FORMAT: state_d = EXEC;
                    BEQ:      state_d = BRANCH;
                    J:        state_d = JUMP;
                    ADDI:     state_d = ADDIEX;
                    default: begin
                        state_d = FETCH;
                        op_bad  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                case (op)
                    LW:      state_d = MEMRD;
                    SW:      state_d = MEMWR;
                    default: state_d = FETCH;
                endcase
            end
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = RWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Everything, including the debug state, reads 0 while in reset.
    assign PCWrite     = reset_n & ctrl.pc_write;
    assign PCWriteCond = reset_n & ctrl.pc_write_cond;
    assign PCSource    = {2{reset_n}} & ctrl.pc_source;
    assign IorD        = reset_n & ctrl.iord;
    assign MemRead     = reset_n & ctrl.mem_read;
    assign MemWrite    = reset_n & ctrl.mem_write;
    assign IRWrite     = reset_n & ctrl.ir_write;
    assign MemtoReg    = reset_n & ctrl.mem_to_reg;
    assign RegDst      = reset_n & ctrl.reg_dst;
    assign RegWrite    = reset_n & ctrl.reg_write;
    assign ALUSrcA     = reset_n & ctrl.alu_src_a;
    assign ALUSrcB     = {2{reset_n}} & ctrl.alu_src_b;
    assign ALUOp       = {2{reset_n}} & ctrl.alu_op;
    assign instr_done  = reset_n & ctrl.instr_done;
    assign illegal_op  = reset_n & op_bad;
    assign state       = {STATE_W{reset_n}} & state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, lw, stalled sw,
// R/beq/j/addi sequence, fetch stall, illegal op and mid-lw reset.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    multicycle_control dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        op        = 6'd0;
        step();
        step();
        chk("rst_state", state, 4'd0);
        chk("rst_memread", 4'(MemRead), 4'd0);
        chk("rst_srcb", 4'(ALUSrcB), 4'd0);
        chk("rst_irwrite", 4'(IRWrite), 4'd0);
        chk("rst_pcwrite", 4'(PCWrite), 4'd0);

        // lw, no wait states
        reset_n = 1'b1;
        op      = 6'd35;
        #1;
        chk("fetch_state", state, 4'd0);
        chk("fetch_memread", 4'(MemRead), 4'd1);
        chk("fetch_srcb", 4'(ALUSrcB), 4'd1);
        chk("fetch_irwrite", 4'(IRWrite), 4'd1);
        step();
        chk("lw_decode", state, 4'd1);
        chk("decode_srcb", 4'(ALUSrcB), 4'd3);
        step();
        chk("lw_memadr", state, 4'd2);
        chk("memadr_srca", 4'(ALUSrcA), 4'd1);
        chk("memadr_srcb", 4'(ALUSrcB), 4'd2);
        step();
        chk("lw_memrd", state, 4'd3);
        chk("memrd_read", 4'(MemRead), 4'd1);
        chk("memrd_iord", 4'(IorD), 4'd1);
        chk("memrd_done", 4'(instr_done), 4'd0);
        step();
        chk("lw_memwb", state, 4'd4);
        chk("memwb_done", 4'(instr_done), 4'd1);
        chk("memwb_regwr", 4'(RegWrite), 4'd1);
        chk("memwb_m2r", 4'(MemtoReg), 4'd1);
        chk("memwb_regdst", 4'(RegDst), 4'd0);
        step();
        chk("lw_end", state, 4'd0);

        // sw with three wait cycles in MEMWR
        op = 6'd43;
        step();
        step();
        chk("sw_memadr", state, 4'd2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sw_wait_state", state, 4'd5);
            chk("sw_wait_write", 4'(MemWrite), 4'd1);
            chk("sw_wait_iord", 4'(IorD), 4'd1);
            chk("sw_wait_read", 4'(MemRead), 4'd0);
            chk("sw_wait_done", 4'(instr_done), 4'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_rdy_write", 4'(MemWrite), 4'd1);
        chk("sw_rdy_done", 4'(instr_done), 4'd1);
        chk("sw_rdy_read", 4'(MemRead), 4'd0);
        step();
        chk("sw_end", state, 4'd0);

        // R-format: 4 cycles
        op = 6'd0;
        step();
        step();
        chk("r_exec", state, 4'd6);
        chk("exec_aluop", 4'(ALUOp), 4'd2);
        chk("exec_srcb", 4'(ALUSrcB), 4'd0);
        step();
        chk("r_rwb", state, 4'd7);
        chk("rwb_regdst", 4'(RegDst), 4'd1);
        chk("rwb_done", 4'(instr_done), 4'd1);
        step();
        chk("r_end", state, 4'd0);

        // beq: 3 cycles
        op = 6'd4;
        step();
        step();
        chk("beq_branch", state, 4'd8);
        chk("br_pcwcond", 4'(PCWriteCond), 4'd1);
        chk("br_pcsrc", 4'(PCSource), 4'd1);
        chk("br_aluop", 4'(ALUOp), 4'd1);
        chk("br_done", 4'(instr_done), 4'd1);
        step();
        chk("beq_end", state, 4'd0);

        // j: 3 cycles
        op = 6'd2;
        step();
        step();
        chk("j_jump", state, 4'd9);
        chk("j_pcwrite", 4'(PCWrite), 4'd1);
        chk("j_pcsrc", 4'(PCSource), 4'd2);
        step();
        chk("j_end", state, 4'd0);

        // addi: 4 cycles
        op = 6'd8;
        step();
        step();
        chk("addi_ex", state, 4'd10);
        chk("addiex_srcb", 4'(ALUSrcB), 4'd2);
        step();
        chk("addi_wb", state, 4'd11);
        chk("addiwb_regdst", 4'(RegDst), 4'd0);
        chk("addiwb_m2r", 4'(MemtoReg), 4'd0);
        chk("addiwb_regwr", 4'(RegWrite), 4'd1);
        step();
        chk("addi_end", state, 4'd0);

        // Fetch stall for two edges
        mem_ready = 1'b0;
        #1;
        chk("stall_irwrite", 4'(IRWrite), 4'd0);
        chk("stall_pcwrite", 4'(PCWrite), 4'd0);
        chk("stall_memread", 4'(MemRead), 4'd1);
        step();
        step();
        chk("stall_state", state, 4'd0);
        chk("stall_irwrite2", 4'(IRWrite), 4'd0);
        mem_ready = 1'b1;
        op        = 6'd63;
        #1;
        chk("ready_irwrite", 4'(IRWrite), 4'd1);
        chk("ready_pcwrite", 4'(PCWrite), 4'd1);

        // Illegal opcode
        step();
        chk("ill_decode", state, 4'd1);
        chk("ill_pulse", 4'(illegal_op), 4'd1);
        step();
        chk("ill_fetch", state, 4'd0);
        chk("ill_clear", 4'(illegal_op), 4'd0);

        // Reset in the middle of lw
        op = 6'd35;
        step();
        step();
        step();
        chk("mid_memrd", state, 4'd3);
        chk("mid_regwr", 4'(RegWrite), 4'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_read", 4'(MemRead), 4'd0);
        chk("mid_rst_iord", 4'(IorD), 4'd0);
        step();
        chk("mid_rst_state", state, 4'd0);
        chk("mid_rst_regwr", 4'(RegWrite), 4'd0);
        reset_n = 1'b1;
        #1;
        chk("mid_rel_state", state, 4'd0);
        chk("mid_rel_read", 4'(MemRead), 4'd1);
        chk("mid_rel_regwr", 4'(RegWrite), 4'd0);
        step();
        chk("mid_rel_decode", state, 4'd1);
        chk("mid_rel_regwr2", 4'(RegWrite), 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
